// File: rtl/flick_sequencer.sv
`timescale 1ns/1ps
// Front-end controller for the bound flasher: button conditioning,
// auto-replay, step pacing and run start/finish tracking from the LED bus.
module flick_sequencer #(
  parameter int DEBOUNCE_CYC   = 16,
  parameter int TICK_DIV       = 4,
  parameter int ARM_TIMEOUT    = 8,
  parameter int COOLDOWN_TICKS = 4,
  parameter int AUTO_GAP       = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_raw,
  input  logic        auto_en,
  input  logic [15:0] leds_in,
  output logic        flick,
  output logic        step_en,
  output logic        busy,
  output logic        arm_err,
  output logic [7:0]  run_count
);

  localparam int DBW  = $clog2(DEBOUNCE_CYC);
  localparam int DVW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = (ARM_TIMEOUT > COOLDOWN_TICKS) ?
                        ARM_TIMEOUT : COOLDOWN_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int AW   = $clog2(AUTO_GAP + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_COOL
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_btn_db;
  logic             r_btn_prev;
  logic [DBW-1:0]   r_db_cnt;
  logic [DVW-1:0]   r_div;
  logic [TW-1:0]    r_tcnt;
  logic [AW-1:0]    r_auto_cnt;
  logic             r_flick;
  logic             r_busy;
  logic             r_arm_err;
  logic [7:0]       r_run_count;

  logic             w_tick;
  logic             w_press;
  logic             w_leds_on;
  logic             w_auto_fire;

  assign w_tick      = (r_div == DVW'(TICK_DIV - 1));
  assign w_press     = r_btn_db & ~r_btn_prev;
  assign w_leds_on   = |leds_in;
  assign w_auto_fire = auto_en & w_tick &
                       (r_auto_cnt == AW'(AUTO_GAP - 1));

  assign flick     = r_flick;
  assign step_en   = w_tick;
  assign busy      = r_busy;
  assign arm_err   = r_arm_err;
  assign run_count = r_run_count;

  // Any sample that agrees with the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_btn_db   <= 1'b0;
      r_btn_prev <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_sync1    <= btn_raw;
      r_sync2    <= r_sync1;
      r_btn_prev <= r_btn_db;
      if (r_sync2 == r_btn_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DBW'(DEBOUNCE_CYC - 1)) begin
        r_btn_db <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_flick     <= 1'b0;
      r_busy      <= 1'b0;
      r_arm_err   <= 1'b0;
      r_run_count <= '0;
      r_tcnt      <= '0;
      r_auto_cnt  <= '0;
    end else begin
      r_busy     <= (r_state != S_IDLE);
      r_flick    <= (r_state == S_ARM) |
                    ((r_state == S_RUN) & r_btn_db);
      r_auto_cnt <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_press || w_auto_fire) begin
            r_state   <= S_ARM;
            r_tcnt    <= '0;
            r_arm_err <= 1'b0;
          end else if (auto_en) begin
            r_auto_cnt <= r_auto_cnt + AW'(w_tick);
          end
        end
        S_ARM: begin
          // LED activity wins even on the timeout tick.
          if (w_leds_on) begin
            r_state <= S_RUN;
          end else if (w_tick) begin
            if (r_tcnt == TW'(ARM_TIMEOUT - 1)) begin
              r_state   <= S_IDLE;
              r_arm_err <= 1'b1;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!w_leds_on) begin
            r_state <= S_COOL;
            r_tcnt  <= '0;
            if (r_run_count != 8'hFF) begin
              r_run_count <= r_run_count + 1'b1;
            end
          end
        end
        S_COOL: begin
          if (w_tick) begin
            if (r_tcnt == TW'(COOLDOWN_TICKS - 1)) begin
              r_state <= S_IDLE;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flick_sequencer.sv
`timescale 1ns/1ps
// Bench for flick_sequencer: directed table, corner sequences and
// randomized traffic against a tick-bookkeeping reference model.
module tb_flick_sequencer;

  localparam int D  = 16;
  localparam int TD = 4;
  localparam int AT = 8;
  localparam int CT = 4;
  localparam int AG = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_raw = 1'b0;
  logic        auto_en = 1'b0;
  logic [15:0] leds_in = '0;
  logic        flick;
  logic        step_en;
  logic        busy;
  logic        arm_err;
  logic [7:0]  run_count;

  int n_cmp = 0;
  int n_bad = 0;

  flick_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .auto_en   (auto_en),
    .leds_in   (leds_in),
    .flick     (flick),
    .step_en   (step_en),
    .busy      (busy),
    .arm_err   (arm_err),
    .run_count (run_count)
  );

  always #5 clk = ~clk;

  // Reference model: time is kept as edge and tick totals; state
  // timeouts are differences against the tick total at entry.
  int m_k, m_ticks, m_entry, m_amark, m_st, m_rc;
  bit m_err, m_flick, m_busy, m_db, m_dbp, m_s1, m_s2;
  bit m_hist[$];

  function automatic void m_reset();
    m_k = 0; m_ticks = 0; m_entry = 0; m_amark = 0;
    m_st = 0; m_rc = 0; m_err = 0; m_flick = 0; m_busy = 0;
    m_db = 0; m_dbp = 0; m_s1 = 0; m_s2 = 0;
    m_hist.delete();
  endfunction

  function automatic void m_edge();
    bit tk, pr, all_eq;
    int nst;
    if (rst) begin
      m_reset();
      return;
    end
    tk = (m_k % TD) == TD - 1;
    m_k++;
    if (tk) m_ticks++;
    pr = m_db && !m_dbp;
    m_flick = (m_st == 1) || (m_st == 2 && m_db);
    m_busy = (m_st != 0);
    nst = m_st;
    case (m_st)
      0: begin
        if (pr || (auto_en && tk && m_ticks - m_amark == AG)) begin
          nst = 1; m_err = 0; m_entry = m_ticks;
        end
        if (nst != 0 || !auto_en) m_amark = m_ticks;
      end
      1: begin
        if (leds_in != 0) nst = 2;
        else if (tk && m_ticks - m_entry == AT) begin
          nst = 0; m_err = 1;
        end
      end
      2: begin
        if (leds_in == 0) begin
          nst = 3; m_entry = m_ticks;
          if (m_rc < 255) m_rc++;
        end
      end
      default: if (tk && m_ticks - m_entry == CT) nst = 0;
    endcase
    if (m_st != 0) m_amark = m_ticks;
    m_st = nst;
    m_hist.push_back(m_s2);
    if (m_hist.size() > D) void'(m_hist.pop_front());
    all_eq = (m_hist.size() == D);
    foreach (m_hist[i]) if (m_hist[i] != m_s2) all_eq = 0;
    m_dbp = m_db;
    if (all_eq && m_s2 != m_db) m_db = m_s2;
    m_s2 = m_s1;
    m_s1 = btn_raw;
  endfunction

  task automatic cmp_model();
    bit exp_se;
    exp_se = (m_k % TD) == TD - 1;
    n_cmp++;
    if ({flick, busy, arm_err, step_en, run_count} !==
        {m_flick, m_busy, m_err, exp_se, 8'(m_rc)}) begin
      n_bad++;
      $display("FAIL model t=%0t: got f%0b b%0b e%0b s%0b rc%0d, expected f%0b b%0b e%0b s%0b rc%0d",
               $time, flick, busy, arm_err, step_en, run_count,
               m_flick, m_busy, m_err, exp_se, m_rc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      m_edge();
      #1;
      cmp_model();
    end
  endtask

  task automatic chk(input string nm, input bit ef, input bit eb,
                     input bit ee, input int erc);
    n_cmp++;
    if ({flick, busy, arm_err, run_count} !== {ef, eb, ee, 8'(erc)}) begin
      n_bad++;
      $display("FAIL %s: got f%0b b%0b e%0b rc%0d, expected f%0b b%0b e%0b rc%0d",
               nm, flick, busy, arm_err, run_count, ef, eb, ee, erc);
    end
  endtask

  task automatic drive(input bit r, input bit b, input bit a,
                       input logic [15:0] l);
    rst = r; btn_raw = b; auto_en = a; leds_in = l;
  endtask

  task automatic one_run();
    drive(0, 1, 0, 16'h0); step(20);
    drive(0, 1, 0, 16'h0001); step(2);
    drive(0, 0, 0, 16'h0); step(20);
  endtask

  typedef struct {
    bit          r, b, a;
    logic [15:0] l;
    int          n;
    bit          ef, eb, ee;
    int          erc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit b, bit a, logic [15:0] l, int n,
                              bit ef, bit eb, bit ee, int erc);
    vec_t v;
    v.r = r; v.b = b; v.a = a; v.l = l; v.n = n;
    v.ef = ef; v.eb = eb; v.ee = ee; v.erc = erc;
    tbl.push_back(v);
  endfunction

  initial begin
    m_reset();
    // reset, then step_en must land on every 4th clock
    drive(1, 0, 0, 16'h0); step(2);
    drive(0, 0, 0, 16'h0);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      n_cmp++;
      if (step_en !== ((i % 4) == 3)) begin
        n_bad++;
        $display("FAIL step_en[%0d]: got %0b expected %0b",
                 i, step_en, (i % 4) == 3);
      end
    end

    //   r  b  a  leds     n    f  b  e  rc
    add(1, 0, 0, 16'h0,    2,   0, 0, 0, 0);
    add(0, 0, 0, 16'h0,  100,   0, 0, 0, 0);
    add(0, 1, 0, 16'h0,   19,   0, 0, 0, 0);
    add(0, 1, 0, 16'h0,    1,   1, 1, 0, 0);
    add(0, 1, 0, 16'h1,    3,   1, 1, 0, 0);
    add(0, 0, 0, 16'h1,   18,   1, 1, 0, 0);
    add(0, 0, 0, 16'h1,    1,   0, 1, 0, 0);
    add(0, 0, 0, 16'h0,    1,   0, 1, 0, 1);
    add(0, 0, 0, 16'h0,   20,   0, 0, 0, 1);
    add(0, 1, 0, 16'h0,   20,   1, 1, 0, 1);
    add(0, 1, 0, 16'h0,   10,   1, 1, 0, 1);
    add(0, 1, 0, 16'h0,   25,   0, 0, 1, 1);
    add(0, 0, 0, 16'h0,   20,   0, 0, 1, 1);
    add(0, 1, 0, 16'h0,   20,   1, 1, 0, 1);
    add(0, 0, 0, 16'h0,   40,   0, 0, 1, 1);
    add(0, 0, 1, 16'h0,  120,   0, 0, 1, 1);
    add(0, 0, 1, 16'h0,   12,   1, 1, 0, 1);
    add(0, 0, 0, 16'h8000, 4,   0, 1, 0, 1);
    add(0, 0, 0, 16'h0,   20,   0, 0, 0, 2);
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].b, tbl[i].a, tbl[i].l);
      step(tbl[i].n);
      chk($sformatf("row%0d", i), tbl[i].ef, tbl[i].eb,
          tbl[i].ee, tbl[i].erc);
    end

    // bounce 1,0,1 then held: one press, ARM 18 clk after last bounce
    drive(0, 1, 0, 16'h0); step(1);
    drive(0, 0, 0, 16'h0); step(1);
    drive(0, 1, 0, 16'h0); step(19);
    chk("bounce_pre", 0, 0, 0, 2);
    step(1);
    chk("bounce_arm", 1, 1, 0, 2);
    drive(0, 1, 0, 16'h0004); step(3);
    drive(0, 0, 0, 16'h0); step(25);
    chk("bounce_done", 0, 0, 0, 3);

    // press landing in COOLDOWN is dropped
    drive(0, 1, 0, 16'h0); step(20);
    drive(0, 1, 0, 16'h0010); step(2);
    drive(0, 0, 0, 16'h0010); step(20);
    chk("run_db_low", 0, 1, 0, 3);
    drive(0, 1, 0, 16'h0010); step(8);
    drive(0, 1, 0, 16'h0); step(30);
    chk("cool_drop", 0, 0, 0, 4);
    drive(0, 0, 0, 16'h0); step(20);
    chk("cool_after", 0, 0, 0, 4);

    // reset mid-RUN with five completed runs
    drive(1, 0, 0, 16'h0); step(1);
    drive(0, 0, 0, 16'h0); step(4);
    repeat (5) one_run();
    chk("five_runs", 0, 0, 0, 5);
    drive(0, 1, 0, 16'h0); step(20);
    drive(0, 1, 0, 16'h0001); step(3);
    chk("in_run", 1, 1, 0, 5);
    drive(1, 1, 0, 16'h0001); step(1);
    chk("rst_mid_run", 0, 0, 0, 0);
    drive(0, 0, 0, 16'h0); step(20);
    chk("post_rst", 0, 0, 0, 0);

    // saturation
    repeat (260) one_run();
    chk("saturate", 0, 0, 0, 255);

    // randomized traffic, model checked every cycle
    for (int s = 0; s < 200; s++) begin
      logic [15:0] l;
      l = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(1, 65535)) : 16'h0;
      drive(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), l);
      step(rst ? 1 : $urandom_range(1, 40));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
